// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial-add scheduler.
// Defining SERIAL_ADD_SCHED_CARRY_OUT_EN widens the result by one carry-out bit.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_N_REQ = 2;

`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
    localparam int CARRY_BITS = 1;
`else
    localparam int CARRY_BITS = 0;
`endif

    function automatic int res_width(input int w);
        return w + CARRY_BITS;
    endfunction

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial full adder with a carry register that self-clears on the last bit.
// The carry-out port exists only when SERIAL_ADD_SCHED_CARRY_OUT_EN is defined.
module serial_add_core (
    input  logic clk,
    input  logic rst_n,
    input  logic vld,
    input  logic last,
    input  logic a,
    input  logic b,
`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
    output logic cout,
`endif
    output logic sum
);

    logic carry;
    logic carry_next;

    assign sum        = a ^ b ^ carry;
    assign carry_next = (a & b) | (carry & (a ^ b));

`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
    assign cout = carry_next;
`endif

    // Clearing on the last bit leaves the core ready for the next word without an extra cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (vld) begin
            carry <= last ? 1'b0 : carry_next;
        end
    end

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin front end sharing one bit-serial adder among N_REQ parallel requesters.
// SERIAL_ADD_SCHED_CARRY_OUT_EN adds the final carry as the MSB of res_sum.
module serial_add_scheduler
    import serial_add_pkg::*;
#(
    parameter  int W     = DEF_W,
    parameter  int N_REQ = DEF_N_REQ,
    localparam int RES_W = res_width(W),
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_vld,
    output logic [N_REQ-1:0]         req_rdy,
    input  logic [N_REQ-1:0][W-1:0]  req_a,
    input  logic [N_REQ-1:0][W-1:0]  req_b,
    output logic                     res_vld,
    input  logic                     res_rdy,
    output logic [RES_W-1:0]         res_sum,
    output logic [ID_W-1:0]          res_id
);

    localparam int CNT_W = $clog2(W);

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  pos;
    logic [ID_W-1:0]  cur_id;
    logic             grant_any;
    logic             accept;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     res_sr;
    logic [CNT_W-1:0] bit_cnt;
    logic             core_vld;
    logic             core_last;
    logic             core_sum;
    int               arb_j;

    // Search upward from rr_ptr with wrap-around; the first valid requester wins
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        pos       = '0;
        arb_j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            arb_j = int'(rr_ptr) + i;
            if (arb_j >= N_REQ) begin
                arb_j = arb_j - N_REQ;
            end
            pos = ID_W'(arb_j);
            if (!grant_any && req_vld[pos]) begin
                grant_any = 1'b1;
                grant_idx = pos;
                sel_a     = req_a[pos];
                sel_b     = req_b[pos];
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_rdy[k] = rst_n && (state == IDLE) && grant_any && (grant_idx == ID_W'(k));
        end
    end

    assign accept = (state == IDLE) && grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_any) state_next = SHIFT;
            SHIFT:   if (core_last) state_next = DONE;
            DONE:    if (res_rdy)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        res_vld   = (state == DONE);
        core_vld  = (state == SHIFT);
        core_last = (state == SHIFT) && (bit_cnt == CNT_W'(W - 1));
    end

    // Sum bits enter from the MSB so that after W shifts bit 0 sits at res_sr[0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            bit_cnt <= '0;
            op_a    <= '0;
            op_b    <= '0;
            cur_id  <= '0;
            res_sr  <= '0;
        end else if (accept) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            cur_id  <= grant_idx;
            rr_ptr  <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            bit_cnt <= '0;
        end else if (core_vld) begin
            res_sr  <= {core_sum, res_sr[W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
    logic core_cout;
    logic carry_q;

    serial_add_core u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .vld  (core_vld),
        .last (core_last),
        .a    (op_a[bit_cnt]),
        .b    (op_b[bit_cnt]),
        .cout (core_cout),
        .sum  (core_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (core_last) begin
            carry_q <= core_cout;
        end
    end

    assign res_sum = {carry_q, res_sr};
`else
    serial_add_core u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .vld  (core_vld),
        .last (core_last),
        .a    (op_a[bit_cnt]),
        .b    (op_b[bit_cnt]),
        .sum  (core_sum)
    );

    assign res_sum = res_sr;
`endif

    assign res_id = cur_id;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Self-checking bench for serial_add_scheduler: vector table plus hand-written
// arbitration, back-pressure and reset sequences, results checked through a scoreboard.
module tb_serial_add_scheduler;
    import serial_add_pkg::*;

    localparam int W     = 8;
    localparam int N_REQ = 2;
    localparam int RES_W = res_width(W);
    localparam int ID_W  = 1;
    localparam int NVEC  = 7;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   full;
    } vec_t;

    typedef struct {
        logic [RES_W-1:0] sum;
        int               id;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_vld;
    logic [N_REQ-1:0]        req_rdy;
    logic [N_REQ-1:0][W-1:0] req_a;
    logic [N_REQ-1:0][W-1:0] req_b;
    logic                    res_vld;
    logic                    res_rdy;
    logic [RES_W-1:0]        res_sum;
    logic [ID_W-1:0]         res_id;

    int   checks = 0;
    int   errors = 0;
    int   exp_ptr = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[NVEC];
    logic [W-1:0] held_a[N_REQ];
    logic [W-1:0] held_b[N_REQ];
    logic [W:0]   held_full[N_REQ];

    serial_add_scheduler #(.W(W), .N_REQ(N_REQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_vld(req_vld),
        .req_rdy(req_rdy),
        .req_a  (req_a),
        .req_b  (req_b),
        .res_vld(res_vld),
        .res_rdy(res_rdy),
        .res_sum(res_sum),
        .res_id (res_id)
    );

    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] fits(input logic [W:0] full);
        return full[RES_W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Results are popped from the scoreboard whenever the result handshake completes
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("req_rdy_onehot0", {31'b0, $onehot0(req_rdy)}, 32'd1);
            if (res_vld && res_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_result: got sum 0x%0h id %0d, expected no result", res_sum, res_id);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("res_sum", 32'(res_sum), 32'(mon_e.sum));
                    checkOutput("res_id", 32'(res_id), mon_e.id);
                end
            end
        end
    end

    task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W:0] full);
        bit seen;
        seen = 1'b0;
        sb.push_back('{sum: fits(full), id: id});
        req_a[id]   = a;
        req_b[id]   = b;
        req_vld[id] = 1'b1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (req_rdy[id]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL grant_timeout: requester %0d got no req_rdy, expected one within 50 cycles", id);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        req_vld[id] = 1'b0;
        req_a[id]   = ~a;
        req_b[id]   = ~b;
        if (seen) exp_ptr = (id + 1) % N_REQ;
    endtask

    task automatic serveHeld(input int first, input int count);
        int g;
        int n;
        int want;
        g = 0;
        n = 0;
        for (int k = 0; k < count; k++) begin
            want = (first + k) % N_REQ;
            sb.push_back('{sum: fits(held_full[want]), id: want});
        end
        for (int r = 0; r < N_REQ; r++) begin
            req_a[r] = held_a[r];
            req_b[r] = held_b[r];
        end
        req_vld = '1;
        while (g < count && n < 400) begin
            @(negedge clk);
            n++;
            if (rst_n && req_rdy != '0) begin
                want = (first + g) % N_REQ;
                checkOutput("grant_order", 32'(req_rdy), 32'(1) << want);
                g++;
                if (g == count) begin
                    @(posedge clk);
                    #1;
                    req_vld = '0;
                end
            end
        end
        checks++;
        if (g != count) begin
            errors++;
            req_vld = '0;
            $display("[TB] FAIL held_grants: got %0d grants, expected %0d", g, count);
        end
        exp_ptr = (first + count) % N_REQ;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sb.size() != 0 || res_vld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lat;
        bit  got;

        vecs[0] = '{id: 0, a: 8'h35, b: 8'h4A, full: 9'h07F};
        vecs[1] = '{id: 0, a: 8'hFF, b: 8'h01, full: 9'h100};
        vecs[2] = '{id: 1, a: 8'h80, b: 8'h80, full: 9'h100};
        vecs[3] = '{id: 1, a: 8'h00, b: 8'h00, full: 9'h000};
        vecs[4] = '{id: 0, a: 8'hAA, b: 8'h55, full: 9'h0FF};
        vecs[5] = '{id: 1, a: 8'h7F, b: 8'h01, full: 9'h080};
        vecs[6] = '{id: 0, a: 8'h99, b: 8'h99, full: 9'h132};

        rst_n   = 1'b0;
        req_vld = 2'b01;
        req_a   = '0;
        req_b   = '0;
        res_rdy = 1'b1;
        #12;
        checkOutput("reset_res_vld", 32'(res_vld), 0);
        checkOutput("reset_res_sum", 32'(res_sum), 0);
        checkOutput("reset_res_id", 32'(res_id), 0);
        checkOutput("reset_req_rdy_gated", 32'(req_rdy), 0);
        req_vld = '0;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].full);
            lat = 0;
            got = 1'b0;
            while (!got && lat < 50) begin
                @(negedge clk);
                if (res_vld) begin
                    got = 1'b1;
                end else begin
                    @(posedge clk);
                    lat++;
                end
            end
            checkOutput("latency", lat, W);
            @(posedge clk);
            #1;
        end
        waitDrain();

        held_a[0] = 8'h10; held_b[0] = 8'h20; held_full[0] = 9'h030;
        held_a[1] = 8'hC8; held_b[1] = 8'h64; held_full[1] = 9'h12C;
        serveHeld(exp_ptr, 4);
        waitDrain();

        res_rdy = 1'b0;
        applyStimulus(1, 8'h21, 8'h12, 9'h033);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (res_vld) got = 1'b1;
        end
        checkOutput("bp_res_vld_reached", 32'(got), 1);
        req_a[0]   = 8'h05;
        req_b[0]   = 8'h06;
        req_vld[0] = 1'b1;
        sb.push_back('{sum: fits(9'h00B), id: 0});
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_res_vld", 32'(res_vld), 1);
            checkOutput("bp_res_sum", 32'(res_sum), 32'h33);
            checkOutput("bp_res_id", 32'(res_id), 1);
            checkOutput("bp_no_grant", 32'(req_rdy), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_no_grant_yet", 32'(req_rdy), 0);
        @(negedge clk);
        checkOutput("bp_next_grant", 32'(req_rdy), 32'h1);
        @(posedge clk);
        #1;
        req_vld[0] = 1'b0;
        req_a[0]   = 8'hEE;
        req_b[0]   = 8'hEE;
        exp_ptr    = 1;
        waitDrain();

        applyStimulus(0, 8'hFF, 8'hFF, 9'h1FE);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        held_a[0] = 8'h01; held_b[0] = 8'h01; held_full[0] = 9'h002;
        held_a[1] = 8'h40; held_b[1] = 8'h02; held_full[1] = 9'h042;
        req_a[0] = held_a[0]; req_b[0] = held_b[0];
        req_a[1] = held_a[1]; req_b[1] = held_b[1];
        req_vld  = 2'b11;
        sb.delete();
        rst_n = 1'b0;
        #1;
        checkOutput("midshift_reset_res_vld", 32'(res_vld), 0);
        checkOutput("midshift_reset_res_sum", 32'(res_sum), 0);
        checkOutput("midshift_reset_res_id", 32'(res_id), 0);
        checkOutput("midshift_reset_req_rdy", 32'(req_rdy), 0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_req_rdy", 32'(req_rdy), 0);
        rst_n = 1'b1;
        serveHeld(0, 2);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
